// File: rtl/regfile16_pkg.sv
// Shared sizing and types for the 16-entry register file.
// No logic; constants and the register index type only.
// No flow control involved.
package regfile16_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile16_dec.sv
// 4-to-16 one-hot write decoder, all outputs low when the enable is low.
// Latency: combinational.
// Backpressure: none; pure decode.
module dec4_16
    import regfile16_pkg::*;
(
    input  logic                en,
    input  reg_addr_t           addr,
    output logic [NUM_REGS-1:0] onehot
);

    // Raise exactly one enable line for the addressed register when enabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile16_mux.sv
// 16:1 single-bit multiplexer, the building block of each read port.
// Latency: combinational.
// Backpressure: none; pure select.
module mux16_1
    import regfile16_pkg::*;
(
    input  logic [NUM_REGS-1:0] din,
    input  reg_addr_t           sel,
    output logic                dout
);

    assign dout = din[sel];

endmodule

// File: rtl/regfile16.sv
// 16 x WIDTH register file, one write port, two combinational read ports, hardwired-zero entry.
// Latency: writes visible the cycle after the write edge; reads combinational (same cycle with REGFILE16_BYPASS_EN).
// Backpressure: none; every write and read completes unconditionally.
module regfile16
    import regfile16_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  reg_addr_t        wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  reg_addr_t        rd_addr_a,
    input  reg_addr_t        rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b
);

    logic [NUM_REGS-1:0] we;
    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [WIDTH-1:0]    mux_a;
    logic [WIDTH-1:0]    mux_b;

    dec4_16 u_dec (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (we)
    );

    // The zero entry never loads, so its reset value of 0 is what every read of it sees
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        // Register i: cleared asynchronously by reset, loads wr_data on its decoded enable
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                regs[i] <= '0;
            end else if (we[i] && (i != ZERO_REG)) begin
                regs[i] <= wr_data;
            end
        end
    end

    // Each output bit is a 16:1 select over that bit column of all registers
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [NUM_REGS-1:0] col;
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_col
            assign col[i] = regs[i][b];
        end
        mux16_1 u_mux_a (
            .din  (col),
            .sel  (rd_addr_a),
            .dout (mux_a[b])
        );
        mux16_1 u_mux_b (
            .din  (col),
            .sel  (rd_addr_b),
            .dout (mux_b[b])
        );
    end

`ifdef REGFILE16_BYPASS_EN
    logic byp_a;
    logic byp_b;

    // Forward in-flight write data; suppressed in reset so reads stay 0 while the array is held clear
    always_comb begin
        byp_a = reset_n && wr_en && (wr_addr == rd_addr_a) && (wr_addr != ADDR_W'(ZERO_REG));
        byp_b = reset_n && wr_en && (wr_addr == rd_addr_b) && (wr_addr != ADDR_W'(ZERO_REG));
    end

    assign rd_data_a = byp_a ? wr_data : mux_a;
    assign rd_data_b = byp_b ? wr_data : mux_b;
`else
    assign rd_data_a = mux_a;
    assign rd_data_b = mux_b;
`endif

endmodule

// File: tb/tb_regfile16.sv
// Self-checking bench for regfile16: reference model plus expected-value queue.
// Build with +define+REGFILE16_BYPASS_EN to check the forwarding variant.
// Reads are sampled 1 time unit after the falling edge, away from the write edge.
module tb_regfile16;

    localparam int W = 64;

    logic         clk;
    logic         reset_n;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic [3:0]   rd_addr_a;
    logic [3:0]   rd_addr_b;
    logic [W-1:0] rd_data_a;
    logic [W-1:0] rd_data_b;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] mdl [16];
    logic [W-1:0] exp_q [$];

    regfile16 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unknown write address with the write enabled is illegal stimulus
    always @(posedge clk) begin
        if (wr_en === 1'b1) begin
            assert (!$isunknown(wr_addr)) else $error("wr_addr unknown while wr_en=1");
        end
    end

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
    endtask

    // Drive one write through a rising edge and mirror it in the model
    task automatic do_write(input logic [3:0] a, input logic [W-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (a != 4'd15) mdl[a] = d;
    endtask

    // Present read addresses, queue the model's expectations, then compare
    task automatic do_read(input logic [3:0] a, input logic [3:0] b, input string tag);
        @(negedge clk);
        rd_addr_a = a;
        rd_addr_b = b;
        exp_q.push_back(mdl[a]);
        exp_q.push_back(mdl[b]);
        #1;
        check_eq({tag, "_a"}, rd_data_a, exp_q.pop_front());
        check_eq({tag, "_b"}, rd_data_b, exp_q.pop_front());
    endtask

    initial begin
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        mdl_clear();

        // Reset state
        #12;
        exp_q.push_back('0);
        exp_q.push_back('0);
        check_eq("rst_a", rd_data_a, exp_q.pop_front());
        check_eq("rst_b", rd_data_b, exp_q.pop_front());
        @(negedge clk);
        reset_n = 1'b1;

        // Write r0..r14 (and r15, which must be discarded), then sweep both ports
        for (int i = 0; i < 16; i++) do_write(4'(i), W'(64'h1000 + i));
        for (int i = 0; i < 16; i++) do_read(4'(i), 4'(15 - i), $sformatf("sweep%0d", i));

        // Zero register ignores an all-ones write
        do_write(4'd15, {W{1'b1}});
        do_read(4'd15, 4'd15, "zero_reg");

        // Both ports on one register, then independent registers
        do_write(4'd7, W'(64'h77));
        do_read(4'd7, 4'd7, "dual_same");
        do_read(4'd2, 4'd9, "dual_diff");

        // Disabled write leaves r4 untouched
        @(negedge clk);
        wr_en   = 1'b0;
        wr_addr = 4'd4;
        wr_data = W'(64'h1234);
        @(posedge clk);
        do_read(4'd4, 4'd4, "wr_en_low");

        // Same-cycle write/read hazard on r5
        do_write(4'd5, W'(64'h55));
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = 4'd5;
        wr_data   = W'(64'hAA);
        rd_addr_a = 4'd5;
        rd_addr_b = 4'd6;
`ifdef REGFILE16_BYPASS_EN
        exp_q.push_back(W'(64'hAA));
`else
        exp_q.push_back(W'(64'h55));
`endif
        exp_q.push_back(mdl[6]);
        #1;
        check_eq("hazard_pre_a", rd_data_a, exp_q.pop_front());
        check_eq("hazard_pre_b", rd_data_b, exp_q.pop_front());
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        mdl[5] = W'(64'hAA);
        exp_q.push_back(W'(64'hAA));
        #1;
        check_eq("hazard_post", rd_data_a, exp_q.pop_front());

        // Mid-run asynchronous reset after writing r3
        do_write(4'd3, W'(64'hDEAD));
        do_read(4'd3, 4'd5, "pre_reset");
        @(negedge clk);
        #2;
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd5;
        reset_n   = 1'b0;
        mdl_clear();
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1;
        check_eq("async_rst_a", rd_data_a, exp_q.pop_front());
        check_eq("async_rst_b", rd_data_b, exp_q.pop_front());
        // A write attempted across an edge while in reset must be lost
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = W'(64'hBEEF);
        @(posedge clk);
        #1;
        exp_q.push_back('0);
        exp_q.push_back('0);
        check_eq("in_rst_wr_a", rd_data_a, exp_q.pop_front());
        check_eq("in_rst_wr_b", rd_data_b, exp_q.pop_front());
        @(negedge clk);
        wr_en   = 1'b0;
        reset_n = 1'b1;
        do_read(4'd3, 4'd0, "post_reset");

        // Array still writable after reset
        do_write(4'd3, W'(64'hCAFE));
        do_read(4'd3, 4'd14, "post_reset_wr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile16.md
REGFILE16 -- requirements
Module: regfile16

Interface
REQ-001 Parameter WIDTH, default 64: bit width of each register and of every data port.
REQ-002 Parameter ZERO_REG, default 15: index of the hardwired-zero register.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write enable for the single write port.
REQ-006 wr_addr  input  4  destination register index.
REQ-007 wr_data  input  WIDTH  data written to register wr_addr.
REQ-008 rd_addr_a  input  4  read port A register index.
REQ-009 rd_addr_b  input  4  read port B register index.
REQ-010 rd_data_a  output  WIDTH  contents of register rd_addr_a.
REQ-011 rd_data_b  output  WIDTH  contents of register rd_addr_b.

Function
REQ-012 The block SHALL hold 16 registers of WIDTH bits, indices 0..15.
REQ-013 Write: on a rising clk edge with wr_en=1 and reset_n=1, register wr_addr SHALL load wr_data; the value is visible on the read ports in the following cycle.
REQ-014 wr_en=0 SHALL leave all registers unchanged.
REQ-015 Writes to ZERO_REG SHALL be discarded; reads of ZERO_REG SHALL always return 0.
REQ-016 Reads SHALL be combinational: rd_data_x follows rd_addr_x within the same cycle, with no clock latency.
REQ-017 Each read port SHALL be one WIDTH-wide 16:1 selection, one 16:1 bit mux per output bit, select = rd_addr_x.
REQ-018 Both read ports MAY address the same register; both SHALL return identical data.
REQ-019 Read and write to the same index in the same cycle: behaviour is set by REQ-024/REQ-025.
REQ-020 X or Z on wr_addr while wr_en=1 is illegal; the bench SHALL flag it with an assertion.

Reset
REQ-021 reset_n=0 SHALL clear all 16 registers to 0 immediately, without waiting for a clk edge.
REQ-022 While reset_n=0, writes SHALL be ignored and both rd_data ports SHALL read 0.
REQ-023 A write whose clk edge coincides with reset_n=0 SHALL be lost; after release the register reads 0.

Configuration
REQ-024 With macro REGFILE16_BYPASS_EN defined: when wr_en=1, wr_addr==rd_addr_x and wr_addr!=ZERO_REG, rd_data_x SHALL return wr_data combinationally in the same cycle.
REQ-025 Without REGFILE16_BYPASS_EN: rd_data_x SHALL return the pre-edge stored value until the write edge, then the new value.

Structure
REQ-026 Package regfile16_pkg SHALL hold NUM_REGS=16, ADDR_W=4 and typedef reg_addr_t (logic [ADDR_W-1:0]).
REQ-027 Sub-module dec4_16 (4-to-16 one-hot write decoder gated by wr_en) SHALL generate the per-register write enables.
REQ-028 Read selection SHALL instantiate the team's existing 16:1 bit mux, once per bit per port.

Verification
REQ-029 Reset: drive reset_n=0 mid-run after writing 0xDEAD to r3 -> all reads return 0 asynchronously; after release r3 reads 0.
REQ-030 Write/read: write r0..r14 with 0x1000+i, then sweep rd_addr_a 0..15 -> r_i = 0x1000+i, r15 = 0.
REQ-031 Zero register: write 0xFFFF_FFFF_FFFF_FFFF to r15 -> rd_data_a and rd_data_b both read 0.
REQ-032 Dual read: rd_addr_a=rd_addr_b=7 after writing 0x77 to r7 -> both ports 0x77; then rd_addr_a=2, rd_addr_b=9 -> independent values.
REQ-033 Same-cycle hazard: r5=0x55, then write 0xAA to r5 with rd_addr_a=5 -> pre-edge read 0xAA with REGFILE16_BYPASS_EN, 0x55 without; post-edge read 0xAA in both builds.
REQ-034 wr_en=0 with wr_addr=4, wr_data=0x1234 -> r4 keeps its prior value.
